// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings for the hazard controller
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mduState_e;

endpackage

// File: rtl/mdu_stall_seq.sv
// rtl/mdu_stall_seq.sv - holds a multi-cycle MDU op in E for MDU_LAT cycles
module mdu_stall_seq
    import hazard_pkg::*;
#(
    parameter int MDU_LAT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic MdvStartE,
    output logic mdvStall,
    output logic MdvDoneE,
    output logic MdvBusy
);

    localparam int CW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
    localparam bit MULTI = (MDU_LAT > 1);
    // First cycle is spent in IDLE, so BUSY covers the remaining MDU_LAT-1 cycles.
    localparam logic [CW-1:0] CNT_INIT = MULTI ? CW'(MDU_LAT - 2) : '0;

    mduState_e state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MdvStartE && MULTI) begin
                        state <= BUSY;
                        cnt   <= CNT_INIT;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign MdvBusy  = (state == BUSY);
    assign mdvStall = ((state == IDLE) && MdvStartE && MULTI) || (MdvBusy && (cnt != '0));
    assign MdvDoneE = ((state == IDLE) && MdvStartE && !MULTI) || (MdvBusy && (cnt == '0));

endmodule

// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - forwarding, load-use, MDU stall and event counters
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] Rs1D,
    input  logic [ADDR_W-1:0] Rs2D,
    input  logic              Rs1UsedD,
    input  logic              Rs2UsedD,
    input  logic [ADDR_W-1:0] Rs1E,
    input  logic [ADDR_W-1:0] Rs2E,
    input  logic [ADDR_W-1:0] RdE,
    input  logic [ADDR_W-1:0] RdM,
    input  logic [ADDR_W-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ResultSrcE0,
    input  logic              MdvStartE,
    input  logic              PCSrcE,
    input  logic              ClrCnt,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              MdvDoneE,
    output logic              MdvBusy,
    output logic [CNT_W-1:0]  StallCount,
    output logic [CNT_W-1:0]  FlushCount
);

    function automatic logic [1:0] fwdSel(input logic [ADDR_W-1:0] src);
        if (src != '0 && src == RdM && RegWriteM) begin
            return FWD_MEM;
        end else if (src != '0 && src == RdW && RegWriteW) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    logic loadStall;
    logic mdvStall;

    assign ForwardAE = fwdSel(Rs1E);
    assign ForwardBE = fwdSel(Rs2E);

    assign loadStall = ResultSrcE0 && (RdE != '0) &&
                       ((Rs1UsedD && (Rs1D == RdE)) || (Rs2UsedD && (Rs2D == RdE)));

    mdu_stall_seq #(
        .MDU_LAT(MDU_LAT)
    ) u_seq (
        .clk      (clk),
        .reset_n  (reset_n),
        .MdvStartE(MdvStartE),
        .mdvStall (mdvStall),
        .MdvDoneE (MdvDoneE),
        .MdvBusy  (MdvBusy)
    );

    // Branch flush is masked while an MDU op holds E so the held op is never squashed.
    assign StallF = loadStall | mdvStall;
    assign StallD = loadStall | mdvStall;
    assign StallE = mdvStall;
    assign FlushM = mdvStall;
    assign FlushD = PCSrcE & ~mdvStall;
    assign FlushE = loadStall | (PCSrcE & ~mdvStall);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else if (ClrCnt) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (StallF && (StallCount != '1)) StallCount <= StallCount + 1'b1;
            if (FlushD && (FlushCount != '1)) FlushCount <= FlushCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb/tb_hazard_unit_mc.sv - directed bench for hazard_unit_mc
module tb_hazard_unit_mc;

    logic clk = 1'b0;
    logic reset_n;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic Rs1UsedD, Rs2UsedD, RegWriteM, RegWriteW, ResultSrcE0, MdvStartE, PCSrcE, ClrCnt;

    logic [1:0] ForwardAE, ForwardBE, ForwardAE1, ForwardBE1, ForwardAE2, ForwardBE2;
    logic StallF, StallD, StallE, FlushD, FlushE, FlushM, MdvDoneE, MdvBusy;
    logic StallF1, StallD1, StallE1, FlushD1, FlushE1, FlushM1, MdvDoneE1, MdvBusy1;
    logic StallF2, StallD2, StallE2, FlushD2, FlushE2, FlushM2, MdvDoneE2, MdvBusy2;
    logic [15:0] StallCount, FlushCount, StallCount1, FlushCount1;
    logic [1:0] StallCount2, FlushCount2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_unit_mc #(.ADDR_W(5), .MDU_LAT(4), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1UsedD(Rs1UsedD), .Rs2UsedD(Rs2UsedD),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .MdvStartE(MdvStartE), .PCSrcE(PCSrcE), .ClrCnt(ClrCnt),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .MdvDoneE(MdvDoneE), .MdvBusy(MdvBusy),
        .StallCount(StallCount), .FlushCount(FlushCount));

    hazard_unit_mc #(.ADDR_W(5), .MDU_LAT(1), .CNT_W(16)) dut1 (
        .clk(clk), .reset_n(reset_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1UsedD(Rs1UsedD), .Rs2UsedD(Rs2UsedD),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .MdvStartE(MdvStartE), .PCSrcE(PCSrcE), .ClrCnt(ClrCnt),
        .ForwardAE(ForwardAE1), .ForwardBE(ForwardBE1), .StallF(StallF1), .StallD(StallD1), .StallE(StallE1),
        .FlushD(FlushD1), .FlushE(FlushE1), .FlushM(FlushM1), .MdvDoneE(MdvDoneE1), .MdvBusy(MdvBusy1),
        .StallCount(StallCount1), .FlushCount(FlushCount1));

    hazard_unit_mc #(.ADDR_W(5), .MDU_LAT(4), .CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1UsedD(Rs1UsedD), .Rs2UsedD(Rs2UsedD),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .MdvStartE(MdvStartE), .PCSrcE(PCSrcE), .ClrCnt(ClrCnt),
        .ForwardAE(ForwardAE2), .ForwardBE(ForwardBE2), .StallF(StallF2), .StallD(StallD2), .StallE(StallE2),
        .FlushD(FlushD2), .FlushE(FlushE2), .FlushM(FlushM2), .MdvDoneE(MdvDoneE2), .MdvBusy(MdvBusy2),
        .StallCount(StallCount2), .FlushCount(FlushCount2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clrIn();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        Rs1UsedD = 0; Rs2UsedD = 0; RegWriteM = 0; RegWriteW = 0;
        ResultSrcE0 = 0; MdvStartE = 0; PCSrcE = 0;
    endtask

    initial begin
        clrIn();
        ClrCnt = 0;
        reset_n = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_fwdA", ForwardAE, 2'b00);
        chk("rst_fwdB", ForwardBE, 2'b00);
        chk("rst_stallF", StallF, 0);
        chk("rst_stallE", StallE, 0);
        chk("rst_flushD", FlushD, 0);
        chk("rst_flushE", FlushE, 0);
        chk("rst_flushM", FlushM, 0);
        chk("rst_done", MdvDoneE, 0);
        chk("rst_busy", MdvBusy, 0);
        chk("rst_scnt", StallCount, 0);
        chk("rst_fcnt", FlushCount, 0);

        @(negedge clk);
        reset_n = 1;
        Rs1E = 5; Rs2E = 5; RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1;
        #1;
        chk("fwd_mem_A", ForwardAE, 2'b10);
        chk("fwd_mem_B", ForwardBE, 2'b10);
        RegWriteM = 0;
        #1;
        chk("fwd_wb_A", ForwardAE, 2'b01);
        chk("fwd_wb_B", ForwardBE, 2'b01);
        Rs1E = 0;
        #1;
        chk("fwd_x0_A", ForwardAE, 2'b00);
        chk("fwd_x0_B", ForwardBE, 2'b01);
        clrIn();

        @(negedge clk);
        ResultSrcE0 = 1; RdE = 7; Rs1D = 7; Rs1UsedD = 1;
        #1;
        chk("lu_stallF", StallF, 1);
        chk("lu_stallD", StallD, 1);
        chk("lu_flushE", FlushE, 1);
        chk("lu_stallE", StallE, 0);
        chk("lu_flushD", FlushD, 0);
        Rs1UsedD = 0;
        #1;
        chk("lu_unused_stallF", StallF, 0);
        chk("lu_unused_flushE", FlushE, 0);
        Rs1UsedD = 1; RdE = 0;
        #1;
        chk("lu_x0_stallD", StallD, 0);
        chk("lu_x0_flushE", FlushE, 0);
        clrIn();

        @(negedge clk);
        #1;
        chk("lu_scnt", StallCount, 0);

        @(negedge clk);
        PCSrcE = 1;
        #1;
        chk("br_flushD", FlushD, 1);
        chk("br_flushE", FlushE, 1);
        chk("br_stallF", StallF, 0);
        @(negedge clk);
        @(negedge clk);
        PCSrcE = 0;
        #1;
        chk("br_fcnt", FlushCount, 2);

        @(negedge clk);
        MdvStartE = 1;
        #1;
        chk("mdu_t_stallF", StallF, 1);
        chk("mdu_t_stallD", StallD, 1);
        chk("mdu_t_stallE", StallE, 1);
        chk("mdu_t_flushM", FlushM, 1);
        chk("mdu_t_done", MdvDoneE, 0);
        chk("mdu_t_busy", MdvBusy, 0);
        chk("lat1_done", MdvDoneE1, 1);
        chk("lat1_stallF", StallF1, 0);
        @(negedge clk);
        #1;
        chk("mdu_t1_stallF", StallF, 1);
        chk("mdu_t1_busy", MdvBusy, 1);
        chk("mdu_t1_done", MdvDoneE, 0);
        @(negedge clk);
        PCSrcE = 1;
        #1;
        chk("mdu_t2_stallE", StallE, 1);
        chk("mdu_t2_busy", MdvBusy, 1);
        chk("mdu_br_flushD", FlushD, 0);
        chk("mdu_br_flushE", FlushE, 0);
        @(negedge clk);
        PCSrcE = 0;
        #1;
        chk("mdu_t3_stallF", StallF, 0);
        chk("mdu_t3_flushM", FlushM, 0);
        chk("mdu_t3_done", MdvDoneE, 1);
        chk("mdu_t3_busy", MdvBusy, 1);
        chk("mdu_fcnt", FlushCount, 2);
        @(negedge clk);
        #1;
        chk("b2b_stallF", StallF, 1);
        chk("b2b_busy", MdvBusy, 0);
        chk("b2b_done", MdvDoneE, 0);
        @(negedge clk);
        #1;
        chk("b2b_t1_busy", MdvBusy, 1);

        reset_n = 0;
        MdvStartE = 0;
        #1;
        chk("rmid_busy", MdvBusy, 0);
        chk("rmid_stallF", StallF, 0);
        chk("rmid_done", MdvDoneE, 0);
        chk("rmid_scnt", StallCount, 0);
        chk("rmid_fcnt", FlushCount, 0);
        @(negedge clk);
        reset_n = 1;
        MdvStartE = 1;
        #1;
        chk("rs_t_stallF", StallF, 1);
        chk("rs_t_busy", MdvBusy, 0);
        @(negedge clk);
        #1;
        chk("rs_t1_stallF", StallF, 1);
        @(negedge clk);
        #1;
        chk("rs_t2_stallF", StallF, 1);
        @(negedge clk);
        #1;
        chk("rs_t3_stallF", StallF, 0);
        chk("rs_t3_done", MdvDoneE, 1);
        chk("rs_scnt", StallCount, 3);
        chk("rs_scnt_w2", StallCount2, 3);

        @(negedge clk);
        MdvStartE = 0;
        ClrCnt = 1;
        @(negedge clk);
        #1;
        chk("clr_scnt", StallCount, 0);
        chk("clr_scnt_w2", StallCount2, 0);
        ClrCnt = 0;
        ResultSrcE0 = 1; RdE = 3; Rs2D = 3; Rs2UsedD = 1;
        repeat (5) @(negedge clk);
        #1;
        chk("sat_stallF", StallF, 1);
        chk("sat_scnt_w2", StallCount2, 3);
        chk("sat_scnt", StallCount, 5);
        chk("sat_fcnt", FlushCount, 0);
        ClrCnt = 1;
        @(negedge clk);
        #1;
        chk("clrpri_scnt", StallCount, 0);
        chk("clrpri_scnt_w2", StallCount2, 0);
        ClrCnt = 0;
        clrIn();
        @(negedge clk);
        #1;
        chk("idle_stallF", StallF, 0);
        chk("idle_flushE", FlushE, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit_mc.md
# hazard_unit_mc

Pipeline hazard controller for the five-stage RISC-V core with multi-cycle execute support. It supersedes the combinational hazard logic with a parametrised register-address width and a configurable-latency mul/div (MDU) stall sequencer. Load-use detection is qualified by source use and a non-zero destination, and saturating stall/flush event counters are added. It sits beside the datapath and drives the stall/flush/forward controls of the IF/ID, ID/EX and EX/MEM registers.

## Interface
Parameters:
- ADDR_W, 5, register address width
- MDU_LAT, 4, total E-stage occupancy in cycles of an MDU op (>=1)
- CNT_W, 16, width of each event counter

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous, active-low reset
- Rs1D, Rs2D  in  ADDR_W  D-stage source registers
- Rs1UsedD, Rs2UsedD  in  1  D-stage instruction actually reads Rs1D/Rs2D
- Rs1E, Rs2E, RdE  in  ADDR_W  E-stage sources/destination
- RdM, RdW  in  ADDR_W  M/W destinations
- RegWriteM, RegWriteW  in  1  M/W write enables
- ResultSrcE0  in  1  E-stage instruction is a load
- MdvStartE  in  1  E-stage instruction is an MDU op
- PCSrcE  in  1  taken branch/jump resolved in E
- ClrCnt  in  1  synchronous counter clear
- ForwardAE, ForwardBE  out  2  operand select: 00 RF, 01 W, 10 M
- StallF, StallD, StallE  out  1  hold PC, IF/ID, ID/EX
- FlushD, FlushE, FlushM  out  1  bubble into IF/ID, ID/EX, EX/MEM
- MdvDoneE  out  1  MDU result valid this cycle
- MdvBusy  out  1  sequencer in BUSY
- StallCount, FlushCount  out  CNT_W  event counters

## Operation
- Forwarding (combinational): for each of Rs1E/Rs2E, select 10 if match RdM & RegWriteM & src!=0; otherwise 01 if match RdW & RegWriteW & src!=0; otherwise 00. M has priority over W.
- loadStall = ResultSrcE0 & RdE!=0 & ((Rs1UsedD & Rs1D==RdE) | (Rs2UsedD & Rs2D==RdE)).
- MDU sequencer, states IDLE/BUSY, remaining-stall counter cnt (width clog2(MDU_LAT)):
  - IDLE & MdvStartE & MDU_LAT>1: mdvStall=1 this cycle. Next state BUSY, cnt <= MDU_LAT-2.
  - IDLE & MdvStartE & MDU_LAT==1: MdvDoneE=1, no stall, stay IDLE.
  - BUSY & cnt!=0: mdvStall=1, cnt decrements.
  - BUSY & cnt==0: MdvDoneE=1, mdvStall=0, next state IDLE.
  - MdvStartE is ignored in BUSY, because the same op is held in E.
- Outputs:
  - StallF = StallD = loadStall | mdvStall
  - StallE = mdvStall
  - FlushM = mdvStall
  - FlushD = PCSrcE & ~mdvStall
  - FlushE = loadStall | (PCSrcE & ~mdvStall)
- A taken branch cannot coexist with a load or MDU op in E. The PCSrcE gating is defensive.
- StallCount increments on each cycle with StallF=1. FlushCount increments on each cycle with FlushD=1. Both saturate at all-ones. ClrCnt zeroes both and has priority over increment.

## Timing
- Forwarding, stall and flush outputs are combinational from inputs and state, with zero latency.
- An MDU op entering E at cycle t occupies E for cycles t..t+MDU_LAT-1.
  - Stall is asserted on cycles t..t+MDU_LAT-2.
  - MdvDoneE is asserted on cycle t+MDU_LAT-1.
  - The op advances to M at edge t+MDU_LAT.
- Back-to-back MDU ops: the second op sees IDLE in the cycle after done and starts a new sequence. There is no dead cycle.
- Reset (async, any time, including mid-BUSY) forces:
  - state IDLE, cnt 0, counters 0
  - MdvBusy=0, MdvDoneE=0
  - with all inputs 0: every output 0
- Counters update on the rising clk edge only.

## Structure
- Package hazard_pkg:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - MDU state encodings IDLE/BUSY
- Sub-module mdu_stall_seq (parameter MDU_LAT; ports clk, reset_n, MdvStartE, mdvStall, MdvDoneE, MdvBusy).
- The top level holds forwarding, load-use logic and counters.

## Test plan
- Forwarding priority: Rs1E=Rs2E=5, RdM=RdW=5, RegWriteM=RegWriteW=1 -> ForwardAE=ForwardBE=10. Same with RegWriteM=0 -> 01. Rs1E=0 -> 00.
- Load-use qualification: ResultSrcE0=1, RdE=7, Rs1D=7.
  - Rs1UsedD=1 -> StallF=StallD=FlushE=1.
  - Rs1UsedD=0, or RdE=0 -> all 0.
- MDU latency, MDU_LAT=4, MdvStartE held at t..t+3 -> StallF/StallD/StallE/FlushM=1 on t..t+2, MdvDoneE=1 at t+3 only, MdvBusy=1 on t+1..t+3. MDU_LAT=1 -> MdvDoneE=1 at t with no stall.
- Branch: PCSrcE=1 in IDLE -> FlushD=FlushE=1. PCSrcE=1 during BUSY -> FlushD=0 and FlushE=0.
- Reset mid-BUSY: reset_n low at t+1 of an MDU_LAT=4 op -> MdvBusy=0 and StallF=0 immediately, StallCount=0. After release with MdvStartE=1, the sequence restarts with full 3 stall cycles.
- Counter saturation, CNT_W=2, StallF forced for 5 cycles -> StallCount=3. ClrCnt coincident with stall -> 0.
